// File: rtl/vga_cell_pkg.sv
// vga_cell_pkg: state encoding and default grid constants shared by the cell plotter
package vga_cell_pkg;
   typedef enum logic [2:0] {IDLE, DIV, DRAW, DONE, ERR} state_t;
   localparam int DEF_COLS = 5;
   localparam int DEF_ROWS = 8;
   localparam int NUM_CELLS = DEF_COLS * DEF_ROWS;
   function automatic int num_cells(input int cols, input int rows);
      return cols * rows;
   endfunction
endpackage

// File: rtl/vga_cell_divmod.sv
// vga_cell_divmod: iterative pos -> (row, col) divider by repeated subtraction of COLS
module vga_cell_divmod import vga_cell_pkg::*; #(
   parameter int COLS = DEF_COLS,
   parameter int POS_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [POS_W-1:0] pos,
   output logic             done,
   output logic [POS_W-1:0] row,
   output logic [POS_W-1:0] col
);
   localparam logic [POS_W-1:0] C = POS_W'(COLS);
   logic [POS_W-1:0] rem;
   logic running;
   // done is combinational so the caller can leave its wait state on the same edge
   assign done = running && rem < C;
   assign col = rem;
   always_ff @(posedge clock) begin
      if (reset) begin
         running <= 1'b0;
         rem <= '0;
         row <= '0;
      end else if (start) begin
         running <= 1'b1;
         rem <= pos;
         row <= '0;
      end else if (done) begin
         running <= 1'b0;
      end else if (running) begin
         rem <= rem - C;
         row <= row + POS_W'(1);
      end
   end
endmodule

// File: rtl/vga_cell_plotter.sv
// vga_cell_plotter: turns a linear cell index into a raster sweep of registered pixel writes
module vga_cell_plotter import vga_cell_pkg::*; #(
   parameter int COLS = DEF_COLS,
   parameter int ROWS = DEF_ROWS,
   parameter int CELL_W = 5,
   parameter int CELL_H = 10,
   parameter int X_ORIGIN = 10,
   parameter int Y_ORIGIN = 25,
   parameter int X_W = 8,
   parameter int Y_W = 7,
   parameter int POS_W = 8,
   parameter int COLOUR_W = 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [POS_W-1:0]    req_pos,
   input  logic [COLOUR_W-1:0] req_colour,
   input  logic                req_outline,
   output logic [X_W-1:0]      x,
   output logic [Y_W-1:0]      y,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                busy,
   output logic                done,
   output logic                err
);
   localparam logic [POS_W:0] LIMIT = (POS_W+1)'(num_cells(COLS, ROWS));
   localparam int DX_W = $clog2(CELL_W + 1);
   localparam int DY_W = $clog2(CELL_H + 1);
   localparam logic [DX_W-1:0] DX_LAST = DX_W'(CELL_W - 1);
   localparam logic [DY_W-1:0] DY_LAST = DY_W'(CELL_H - 1);
   state_t state;
   logic [COLOUR_W-1:0] colour_q;
   logic outline_q;
   logic [X_W-1:0] base_x;
   logic [Y_W-1:0] base_y;
   logic [DX_W-1:0] dx;
   logic [DY_W-1:0] dy;
   logic div_start, div_done, in_range, last_dx, last_dy, border;
   logic [POS_W-1:0] div_row, div_col;
   assign req_ready = state == IDLE;
   assign busy = !req_ready;
   assign in_range = {1'b0, req_pos} < LIMIT;
   assign div_start = req_valid && req_ready && in_range;
   assign last_dx = dx == DX_LAST;
   assign last_dy = dy == DY_LAST;
   assign border = dx == '0 || last_dx || dy == '0 || last_dy;
   vga_cell_divmod #(.COLS(COLS), .POS_W(POS_W)) u_divmod (
      .clock(clock),
      .reset(reset),
      .start(div_start),
      .pos(req_pos),
      .done(div_done),
      .row(div_row),
      .col(div_col)
   );
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         x <= '0;
         y <= '0;
         colour <= '0;
         plot <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
         colour_q <= '0;
         outline_q <= 1'b0;
         base_x <= '0;
         base_y <= '0;
         dx <= '0;
         dy <= '0;
      end else begin
         plot <= 1'b0;
         done <= 1'b0;
         err <= 1'b0;
         case (state)
            IDLE: if (req_valid) begin
               colour_q <= req_colour;
               outline_q <= req_outline;
               if (in_range) state <= DIV;
               else state <= ERR;
            end
            // products by constants only; the cell origin is fixed for the whole sweep
            DIV: if (div_done) begin
               base_x <= X_W'(X_ORIGIN) + X_W'(div_col) * X_W'(CELL_W);
               base_y <= Y_W'(Y_ORIGIN) + Y_W'(div_row) * Y_W'(CELL_H);
               dx <= '0;
               dy <= '0;
               state <= DRAW;
            end
            DRAW: begin
               x <= base_x + X_W'(dx);
               y <= base_y + Y_W'(dy);
               colour <= colour_q;
               plot <= !outline_q || border;
               dx <= last_dx ? '0 : dx + DX_W'(1);
               if (last_dx) dy <= last_dy ? '0 : dy + DY_W'(1);
               if (last_dx && last_dy) state <= DONE;
            end
            DONE: begin
               done <= 1'b1;
               state <= IDLE;
            end
            ERR: begin
               err <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vga_cell_plotter.sv
// tb_vga_cell_plotter: randomized scoreboard bench; a reference model predicts every pixel, done and err pulse with its cycle
module tb_vga_cell_plotter;
   localparam int COLS = 5, ROWS = 8, CW = 5, CH = 10, XO = 10, YO = 25;
   localparam int XW = 8, YW = 7, PW = 8, CLW = 3;
   typedef struct {int kind; int cyc; int x; int y; int c;} ev_t;
   logic clock = 1'b0, reset = 1'b1, req_valid = 1'b0, req_outline = 1'b0;
   logic [PW-1:0] req_pos = '0;
   logic [CLW-1:0] req_colour = '0;
   logic req_ready, plot, busy, done, err;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [CLW-1:0] colour;
   int cyc = 0, checks = 0, errors = 0, plot_cnt = 0;
   ev_t q[$];
   ev_t mon_e;
   vga_cell_plotter #(
      .COLS(COLS), .ROWS(ROWS), .CELL_W(CW), .CELL_H(CH), .X_ORIGIN(XO), .Y_ORIGIN(YO),
      .X_W(XW), .Y_W(YW), .POS_W(PW), .COLOUR_W(CLW)
   ) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_pos(req_pos), .req_colour(req_colour), .req_outline(req_outline),
      .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done), .err(err)
   );
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // kind 0 = pixel, 1 = done, 2 = err; cyc = posedge count after which the pulse is visible
   always @(negedge clock) begin
      if (!reset) begin
         while (q.size() != 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_event: kind %0d due at cycle %0d, not seen by cycle %0d", q[0].kind, q[0].cyc, cyc);
            void'(q.pop_front());
         end
         if (plot || done || err) begin
            if (plot) plot_cnt++;
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: plot=%0d done=%0d err=%0d at cycle %0d, expected none", plot, done, err, cyc);
            end else begin
               mon_e = q.pop_front();
               check("event_kind", plot ? 0 : (done ? 1 : 2), mon_e.kind);
               check("event_cycle", cyc, mon_e.cyc);
               if (mon_e.kind == 0) begin
                  check("pixel_x", int'(x), mon_e.x);
                  check("pixel_y", int'(y), mon_e.y);
                  check("pixel_colour", int'(colour), mon_e.c);
               end
            end
         end
      end
   end
   // called at a negedge; returns at the negedge after the accept edge
   task automatic send(input int pos, input int c, input bit ol, input bit keep);
      int a, n, r, cl, dx, dy;
      ev_t ev;
      req_pos = PW'(pos);
      req_colour = CLW'(c);
      req_outline = ol;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 400) begin
         @(negedge clock);
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: req_ready=0 after %0d cycles, expected 1", n);
         req_valid = 1'b0;
         return;
      end
      a = cyc + 1;
      @(posedge clock);
      r = pos / COLS;
      cl = pos % COLS;
      if (pos >= COLS * ROWS) begin
         ev = '{2, a + 1, 0, 0, 0};
         q.push_back(ev);
      end else begin
         // cycle n counted from the accept edge: DIV r+1, DRAW CW*CH, DONE 1, one output register stage
         for (int k = 0; k < CW * CH; k++) begin
            dx = k % CW;
            dy = k / CW;
            if (!ol || dx == 0 || dx == CW - 1 || dy == 0 || dy == CH - 1) begin
               ev = '{0, a + r + 2 + k, (XO + cl * CW + dx) % (1 << XW), (YO + r * CH + dy) % (1 << YW), c};
               q.push_back(ev);
            end
         end
         ev = '{1, a + (1 + (r + 1) + CW * CH + 1) - 1, 0, 0, 0};
         q.push_back(ev);
      end
      @(negedge clock);
      if (!keep) req_valid = 1'b0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while (q.size() != 0 && n < 300) begin
         @(negedge clock);
         n++;
      end
      check("scoreboard_drained", q.size(), 0);
   endtask
   initial begin
      repeat (3) @(negedge clock);
      check("reset_x", int'(x), 0);
      check("reset_y", int'(y), 0);
      check("reset_colour", int'(colour), 0);
      check("reset_plot", int'(plot), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_err", int'(err), 0);
      check("reset_ready", int'(req_ready), 1);
      reset = 1'b0;
      @(negedge clock);
      send(0, 5, 1'b0, 1'b0);
      check("busy_in_div", int'(busy), 1);
      wait_idle();
      send(7, 2, 1'b0, 1'b0);
      wait_idle();
      plot_cnt = 0;
      send(0, 3, 1'b1, 1'b0);
      wait_idle();
      check("outline_plot_count", plot_cnt, 26);
      plot_cnt = 0;
      send(40, 6, 1'b0, 1'b0);
      @(negedge clock);
      @(negedge clock);
      check("err_ready_after", int'(req_ready), 1);
      check("err_busy_after", int'(busy), 0);
      check("err_no_plot", plot_cnt, 0);
      wait_idle();
      send(3, 6, 1'b0, 1'b0);
      repeat (20) @(negedge clock);
      check("draw_busy", int'(busy), 1);
      check("draw_not_ready", int'(req_ready), 0);
      reset = 1'b1;
      @(posedge clock);
      #1;
      q.delete();
      check("abort_plot", int'(plot), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_x", int'(x), 0);
      check("abort_y", int'(y), 0);
      check("abort_colour", int'(colour), 0);
      check("abort_ready", int'(req_ready), 1);
      @(negedge clock);
      reset = 1'b0;
      repeat (5) @(negedge clock);
      send(3, 6, 1'b0, 1'b0);
      wait_idle();
      send(12, 1, 1'b0, 1'b1);
      send(33, 4, 1'b1, 1'b0);
      wait_idle();
      for (int i = 0; i < 30; i++) begin
         bit keep;
         keep = (i < 29) && ($urandom_range(0, 1) == 1);
         send(int'($urandom_range(0, 44)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), keep);
         if (!keep) repeat ($urandom_range(0, 3)) @(negedge clock);
      end
      wait_idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/vga_cell_plotter.md
Name: vga_cell_plotter

Overview:
- Sequential cell renderer between the text/grid logic and the VGA adapter; one cell index in, a filled or outlined rectangle of pixel writes out.
- Maps a linear cell position to grid column and row, offsets by a screen origin, and sweeps every pixel of the cell, one per clock, with registered x/y/colour/plot.
- Generalises the fixed 5-column, 5x10 cell mapping to parametrised grid size, cell size, origin and coordinate widths.
- Adds a request handshake, fill/outline mode, range checking and a completion pulse.

Parameters:
- COLS, 5, grid columns
- ROWS, 8, grid rows; valid positions are 0..COLS*ROWS-1
- CELL_W, 5, cell width in pixels
- CELL_H, 10, cell height in pixels
- X_ORIGIN, 10, pixel x of column 0
- Y_ORIGIN, 25, pixel y of row 0
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- POS_W, 8, position width
- COLOUR_W, 3, colour width

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE
- req_pos  in  POS_W  linear cell index
- req_colour  in  COLOUR_W  draw colour
- req_outline  in  1  0 = fill, 1 = border pixels only
- x  out  X_W  pixel x to adapter
- y  out  Y_W  pixel y to adapter
- colour  out  COLOUR_W  pixel colour
- plot  out  1  pixel write enable
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last pixel cycle
- err  out  1  one-cycle pulse on an out-of-range position

Behaviour:
- Reset (sampled on the clock edge): state IDLE; x=0, y=0, colour=0, plot=0, busy=0, done=0, err=0; req_ready=1 from the following cycle.
- Reset mid-operation aborts the cell immediately; plot is 0 from the next edge and no done is issued.
- Accept: a request is taken when req_valid && req_ready on a clock edge. req_pos, req_colour and req_outline are latched; later input changes are ignored.
- Range check at accept: if req_pos >= COLS*ROWS, go to ERR. ERR lasts 1 cycle with err=1 and plot=0, then returns to IDLE. No done is issued.
- DIV state: a repeated-subtraction divider holds rem (initially pos) and row (initially 0).
  - Each cycle, if rem >= COLS: rem -= COLS, row += 1.
  - Otherwise: col = rem and the next state is DRAW.
  - DIV lasts row+1 cycles. No multiply or divide by a variable is permitted.
- DRAW state: counters dx in 0..CELL_W-1 and dy in 0..CELL_H-1 advance in raster order, dx innermost; one pixel per cycle; exactly CELL_W*CELL_H cycles.
  - Registered outputs: x = X_ORIGIN + col*CELL_W + dx and y = Y_ORIGIN + row*CELL_H + dy, each truncated to X_W/Y_W bits (wrap is modulo 2^width, no saturation). colour = latched colour.
  - plot = 1 every cycle in fill mode.
  - plot = 1 in outline mode only when dx==0, dx==CELL_W-1, dy==0 or dy==CELL_H-1. The sweep still covers all cells, so latency is mode-independent.
  - Outputs lag the counters by one register stage.
- DONE state: 1 cycle, done=1, plot=0, then IDLE.
- Outside DRAW, plot=0; x/y/colour hold their last values.
- Total latency, accept edge to done: 1 + (row+1) + CELL_W*CELL_H + 1 cycles. With the output register, the first plot appears 1 cycle after DIV exits.
- No request is accepted while busy; back-to-back requests are separated by at least the DONE/IDLE cycle.
- Degenerate CELL_W or CELL_H of 1: edges coincide; every pixel is a border pixel.

Decomposition:
- Package vga_cell_pkg holds the state encoding (IDLE, DIV, DRAW, DONE, ERR) and the derived constant NUM_CELLS = COLS*ROWS.
- One sub-module, vga_cell_divmod: the iterative pos -> (row, col) divider with start/done handshake, reusable by the text cursor logic.

Test Plan:
- Defaults, pos=0, fill, colour=3'b101 -> 50 plot cycles; first pixel (10,25), last (14,34); colour 5 throughout; done 1 cycle after the last pixel.
- pos=7 -> DIV 2 cycles; pixels span x 20..24, y 35..44; total accept-to-done = 1+2+50+1 = 54 cycles.
- pos=0, outline -> exactly 26 plot pulses, all on the perimeter of (10..14, 25..34); 50-cycle sweep unchanged.
- pos=40 (= COLS*ROWS) -> err pulses once, zero plot cycles, no done; req_ready high 1 cycle later.
- reset asserted at the 20th DRAW cycle of pos=3 -> plot=0, busy=0 and all outputs at reset values after that edge; no done; the next request draws normally.
- Two requests with req_valid held high -> second accepted only after DONE; inputs changed mid-draw do not alter the first cell.
